// File: rtl/ind_seq_gen.sv
// ---------------------------------------------------------------------------
// ind_seq_gen
//
// Parametrised indicator sequence generator. A WIDTH-bit counter is stepped
// once every PRESC enabled clocks, up or down, and can be parallel-loaded.
// The counter value is presented on a registered indicator bus in one of
// four runtime-selectable encodings. One-cycle step and wrap strobes are
// issued for neighbouring control logic.
//
// Build option:
//   IND_SEQ_BOUNCE_EN  When defined, the counter ping-pongs between 0 and
//                      2^WIDTH-1 using an internal direction flag that is set
//                      from dir only on load. When undefined, the counter
//                      wraps modulo 2^WIDTH and dir is used on every tick.
//
// Parameters:
//   WIDTH     counter / indicator width in bits (>= 2)
//   PRESC     enabled clocks per counter step (>= 1)
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active-low (0 = reset)
//   en        count enable; the prescaler advances only while 1
//   dir       1 = count up, 0 = count down
//   mode      output encoding: 00 binary, 01 Gray,
//             10 bit-reversed binary, 11 bit-reversed Gray
//   load      synchronous parallel load (highest priority)
//   load_val  value loaded into the counter
//   ind_out   encoded indicator value, registered
//   step      one-cycle pulse coincident with each counter advance
//   wrap      one-cycle pulse on wrap-around (turn-around in bounce mode)
// ---------------------------------------------------------------------------
module ind_seq_gen #(
    parameter int WIDTH = 3,
    parameter int PRESC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] ind_out,
    output logic             step,
    output logic             wrap
);

    // Prescaler needs at least one bit even when PRESC == 1.
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0]    PCNT_LAST = PW'(PRESC - 1);
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH-1:0] CNT_ZERO  = '0;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_cnt;
    logic [PW-1:0]    r_pcnt;
    logic [WIDTH-1:0] r_ind;
    logic             r_step;
    logic             r_wrap;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_cnt_next;
    logic [PW-1:0]    w_pcnt_next;
    logic             w_step_next;
    logic             w_wrap_next;
    logic [WIDTH-1:0] w_ind_next;
    logic             w_tick;

    // Tick: the prescaler has completed a full period on an enabled cycle.
    assign w_tick = en && (r_pcnt == PCNT_LAST);

`ifdef IND_SEQ_BOUNCE_EN
    // Internal travel direction for ping-pong counting (1 = up).
    logic r_dir_up;
    logic w_dir_up_next;

    always_comb begin
        w_cnt_next    = r_cnt;
        w_pcnt_next   = r_pcnt;
        w_step_next   = 1'b0;
        w_wrap_next   = 1'b0;
        w_dir_up_next = r_dir_up;

        if (load) begin
            // dir is only consulted here in bounce mode.
            w_cnt_next    = load_val;
            w_pcnt_next   = '0;
            w_dir_up_next = dir;
        end else if (en) begin
            if (w_tick) begin
                w_pcnt_next = '0;
                w_step_next = 1'b1;
                if (r_dir_up) begin
                    if (r_cnt == CNT_MAX) begin
                        // Turn around at the top: reflect to max-1.
                        w_cnt_next    = CNT_MAX - WIDTH'(1);
                        w_dir_up_next = 1'b0;
                        w_wrap_next   = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + WIDTH'(1);
                    end
                end else begin
                    if (r_cnt == CNT_ZERO) begin
                        // Turn around at the bottom: reflect to 1.
                        w_cnt_next    = WIDTH'(1);
                        w_dir_up_next = 1'b1;
                        w_wrap_next   = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt - WIDTH'(1);
                    end
                end
            end else begin
                w_pcnt_next = r_pcnt + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dir_up <= 1'b1;
        end else begin
            r_dir_up <= w_dir_up_next;
        end
    end
`else
    always_comb begin
        w_cnt_next  = r_cnt;
        w_pcnt_next = r_pcnt;
        w_step_next = 1'b0;
        w_wrap_next = 1'b0;

        if (load) begin
            w_cnt_next  = load_val;
            w_pcnt_next = '0;
        end else if (en) begin
            if (w_tick) begin
                w_pcnt_next = '0;
                w_step_next = 1'b1;
                if (dir) begin
                    w_cnt_next  = r_cnt + WIDTH'(1);
                    w_wrap_next = (r_cnt == CNT_MAX);
                end else begin
                    w_cnt_next  = r_cnt - WIDTH'(1);
                    w_wrap_next = (r_cnt == CNT_ZERO);
                end
            end else begin
                w_pcnt_next = r_pcnt + PW'(1);
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output encoder. Encodes the next counter value so that ind_out
    // updates in the same cycle that step rises.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_gray;
    logic [WIDTH-1:0] w_bin_rev;
    logic [WIDTH-1:0] w_gray_rev;

    assign w_gray = w_cnt_next ^ (w_cnt_next >> 1);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign w_bin_rev[gi]  = w_cnt_next[WIDTH-1-gi];
            assign w_gray_rev[gi] = w_gray[WIDTH-1-gi];
        end
    endgenerate

    always_comb begin
        w_ind_next = w_cnt_next;
        case (mode)
            2'b00:   w_ind_next = w_cnt_next;
            2'b01:   w_ind_next = w_gray;
            2'b10:   w_ind_next = w_bin_rev;
            2'b11:   w_ind_next = w_gray_rev;
            default: w_ind_next = w_cnt_next;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_pcnt <= '0;
            r_ind  <= '0;
            r_step <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_pcnt <= w_pcnt_next;
            r_ind  <= w_ind_next;
            r_step <= w_step_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign ind_out = r_ind;
    assign step    = r_step;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_ind_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_ind_seq_gen
//
// Self-checking bench for ind_seq_gen. Two instances run side by side on
// shared stimulus: inst A (WIDTH=3, PRESC=1) and inst B (WIDTH=3, PRESC=3).
// A behavioural model (integer counter, modular arithmetic, encoding by
// formula) predicts every output each cycle; directed scenarios add fixed
// expected sequences.
// ---------------------------------------------------------------------------
module tb_ind_seq_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       dir;
    logic [1:0] mode;
    logic       load;
    logic [2:0] load_val;

    logic [2:0] ind_a, ind_b;
    logic       step_a, step_b, wrap_a, wrap_b;

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = inst A, 1 = inst B
    int         m_cnt  [2];
    int         m_pcnt [2];
    int         m_up   [2];
    logic [2:0] e_ind  [2];
    logic       e_step [2];
    logic       e_wrap [2];
    int         presc_of [2] = '{1, 3};

    always #5 clk = ~clk;

    ind_seq_gen #(.WIDTH(3), .PRESC(1)) u_a (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode),
        .load(load), .load_val(load_val),
        .ind_out(ind_a), .step(step_a), .wrap(wrap_a)
    );

    ind_seq_gen #(.WIDTH(3), .PRESC(3)) u_b (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode),
        .load(load), .load_val(load_val),
        .ind_out(ind_b), .step(step_b), .wrap(wrap_b)
    );

    // Gray = c ^ (c>>1); bit reversal applied afterwards for mode bit 1.
    function automatic logic [2:0] enc(input int c, input int m);
        int         g;
        logic [2:0] v;
        logic [2:0] r;
        g = ((m % 2) == 1) ? (c ^ (c >> 1)) : c;
        v = 3'(g);
        r = v;
        if (m >= 2) begin
            for (int i = 0; i < 3; i++) r[i] = v[2-i];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]  = 0;
            m_pcnt[k] = 0;
            m_up[k]   = 1;
            e_ind[k]  = 3'd0;
            e_step[k] = 1'b0;
            e_wrap[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int nxt;
        for (int k = 0; k < 2; k++) begin
            e_step[k] = 1'b0;
            e_wrap[k] = 1'b0;
            if (load) begin
                m_cnt[k]  = int'(load_val);
                m_pcnt[k] = 0;
                m_up[k]   = dir ? 1 : 0;
            end else if (en) begin
                m_pcnt[k] = m_pcnt[k] + 1;
                if (m_pcnt[k] == presc_of[k]) begin
                    m_pcnt[k] = 0;
                    e_step[k] = 1'b1;
`ifdef IND_SEQ_BOUNCE_EN
                    if (m_up[k] == 1) begin
                        if (m_cnt[k] == 7) begin
                            m_cnt[k] = 6; m_up[k] = 0; e_wrap[k] = 1'b1;
                        end else m_cnt[k] = m_cnt[k] + 1;
                    end else begin
                        if (m_cnt[k] == 0) begin
                            m_cnt[k] = 1; m_up[k] = 1; e_wrap[k] = 1'b1;
                        end else m_cnt[k] = m_cnt[k] - 1;
                    end
`else
                    nxt       = m_cnt[k] + (dir ? 1 : -1);
                    e_wrap[k] = (nxt < 0) || (nxt > 7);
                    m_cnt[k]  = (nxt + 8) % 8;
`endif
                end
            end
            e_ind[k] = enc(m_cnt[k], int'(mode));
        end
    endtask

    task automatic check_model(input string tag);
        checks += 6;
        if (ind_a !== e_ind[0]) begin
            errors++; $display("FAIL %s A.ind_out got %0d expected %0d", tag, ind_a, e_ind[0]);
        end
        if (step_a !== e_step[0]) begin
            errors++; $display("FAIL %s A.step got %0b expected %0b", tag, step_a, e_step[0]);
        end
        if (wrap_a !== e_wrap[0]) begin
            errors++; $display("FAIL %s A.wrap got %0b expected %0b", tag, wrap_a, e_wrap[0]);
        end
        if (ind_b !== e_ind[1]) begin
            errors++; $display("FAIL %s B.ind_out got %0d expected %0d", tag, ind_b, e_ind[1]);
        end
        if (step_b !== e_step[1]) begin
            errors++; $display("FAIL %s B.step got %0b expected %0b", tag, step_b, e_step[1]);
        end
        if (wrap_b !== e_wrap[1]) begin
            errors++; $display("FAIL %s B.wrap got %0b expected %0b", tag, wrap_b, e_wrap[1]);
        end
    endtask

    // One clock: drive, edge, update model, sample 1 time unit later.
    task automatic cycle(input logic i_en, input logic i_dir, input logic [1:0] i_mode,
                         input logic i_load, input logic [2:0] i_lv, input string tag);
        en = i_en; dir = i_dir; mode = i_mode; load = i_load; load_val = i_lv;
        @(posedge clk);
        model_edge();
        #1;
        $display("%s: en=%0b dir=%0b mode=%0d load=%0b lv=%0d -> A ind=%0d st=%0b wr=%0b | B ind=%0d st=%0b wr=%0b",
                 tag, i_en, i_dir, i_mode, i_load, i_lv, ind_a, step_a, wrap_a, ind_b, step_b, wrap_b);
        check_model(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; en = 1'b0; dir = 1'b1; mode = 2'd0; load = 1'b0; load_val = 3'd0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; en = 1'b1; dir = 1'b1; mode = 2'd3; load = 1'b0; load_val = 3'd0;
        model_reset();
        #1;
        check_model("reset_async");
        @(posedge clk);
        #1;
        check_model("reset_hold");
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_binary();
        logic [2:0] tbl [8];
`ifdef IND_SEQ_BOUNCE_EN
        tbl = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6};
`else
        tbl = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
`endif
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 2'd0, 1'b0, 3'd0, "binary");
            checks += 3;
            if (ind_a !== tbl[i]) begin
                errors++; $display("FAIL binary_seq[%0d] got %0d expected %0d", i, ind_a, tbl[i]);
            end
            if (step_a !== 1'b1) begin
                errors++; $display("FAIL binary_step[%0d] got %0b expected 1", i, step_a);
            end
            if (wrap_a !== (i == 7)) begin
                errors++; $display("FAIL binary_wrap[%0d] got %0b expected %0b", i, wrap_a, (i == 7));
            end
        end
    endtask

    task automatic test_encodings();
        logic [2:0] gtbl [8];
        logic [2:0] rtbl [8];
`ifdef IND_SEQ_BOUNCE_EN
        gtbl = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b101};
        rtbl = '{3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111, 3'b011};
`else
        gtbl = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        rtbl = '{3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111, 3'b000};
`endif
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 2'd1, 1'b0, 3'd0, "gray");
            checks++;
            if (ind_a !== gtbl[i]) begin
                errors++; $display("FAIL gray_seq[%0d] got %b expected %b", i, ind_a, gtbl[i]);
            end
        end
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 2'd2, 1'b0, 3'd0, "binrev");
            checks++;
            if (ind_a !== rtbl[i]) begin
                errors++; $display("FAIL binrev_seq[%0d] got %b expected %b", i, ind_a, rtbl[i]);
            end
        end
    endtask

    task automatic test_prescale();
        logic pat [4];
        pat = '{1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(pat[i], 1'b1, 2'd0, 1'b0, 3'd0, "presc");
            checks += 2;
            if (step_b !== (i == 3)) begin
                errors++; $display("FAIL presc_step[%0d] got %0b expected %0b", i, step_b, (i == 3));
            end
            if (ind_b !== ((i == 3) ? 3'd1 : 3'd0)) begin
                errors++; $display("FAIL presc_ind[%0d] got %0d expected %0d", i, ind_b, (i == 3) ? 1 : 0);
            end
        end
    endtask

    task automatic test_load();
        logic [2:0] tbl [6];
`ifdef IND_SEQ_BOUNCE_EN
        tbl = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
`else
        tbl = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
`endif
        do_reset();
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 3'd0, "pre_load");
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 3'd0, "pre_load");
        // Inst B now sits at the last prescaler count; load must win.
        cycle(1'b1, 1'b0, 2'd0, 1'b1, 3'd5, "load");
        checks += 3;
        if (ind_b !== 3'd5) begin
            errors++; $display("FAIL load_ind got %0d expected 5", ind_b);
        end
        if (step_b !== 1'b0) begin
            errors++; $display("FAIL load_step got %0b expected 0", step_b);
        end
        if (ind_a !== 3'd5) begin
            errors++; $display("FAIL load_ind_a got %0d expected 5", ind_a);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 2'd0, 1'b0, 3'd0, "count_down");
            checks += 2;
            if (ind_a !== tbl[i]) begin
                errors++; $display("FAIL down_seq[%0d] got %0d expected %0d", i, ind_a, tbl[i]);
            end
            if (wrap_a !== (i == 5)) begin
                errors++; $display("FAIL down_wrap[%0d] got %0b expected %0b", i, wrap_a, (i == 5));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 2'd0, 1'b0, 3'd0, "to_six");
        checks++;
        if (ind_a !== 3'd6) begin
            errors++; $display("FAIL pre_reset_ind got %0d expected 6", ind_a);
        end
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_model("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 3'd0, "restart");
        checks++;
        if (ind_a !== 3'd1) begin
            errors++; $display("FAIL restart_ind got %0d expected 1", ind_a);
        end
    endtask

    task automatic test_dir_toggle();
        do_reset();
        for (int i = 0; i < 24; i++)
            cycle(1'b1, 1'(i % 2), 2'd0, 1'b0, 3'd0, "dir_toggle");
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom % 2), 2'($urandom % 4),
                  1'($urandom_range(0, 15) == 0), 3'($urandom % 8), "random");
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; dir = 1'b1; mode = 2'd0; load = 1'b0; load_val = 3'd0;
        model_reset();
        test_reset();
        test_binary();
        test_encodings();
        test_prescale();
        test_load();
        test_async_reset();
        test_dir_toggle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
